// File: rtl/bcd_digit_scanner_pkg.sv
// Shared definitions for the multiplexed BCD display scan stage.
package bcd_digit_scanner_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef logic [BCD_W-1:0] bcd_t;

  // Code driven on bcd while nothing meaningful is selected (reset).
  localparam bcd_t BCD_BLANK = '0;

  function automatic logic bcd_valid(input bcd_t d);
    return d <= bcd_t'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_scanner_scan_prescaler.sv
// Slot/digit counters for the display scan. Strobes describe the upcoming edge
// so the parent can register outputs that line up with the counter state.
module scan_prescaler #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx_next,
  output logic             slot_start,
  output logic             show_phase,
  output logic             frame_wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    slot_start = (cnt_q == CNT_W'(PRESCALE - 1));
    frame_wrap = slot_start && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d      = slot_start ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_start) begin
      idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    end
    show_phase = (cnt_d >= CNT_W'(BLANK_CYCLES));
    idx_next   = idx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Multiplexed BCD scan stage: double-buffered display value committed at frame
// boundaries, per-slot blanking, invalid-digit and leading-zero suppression.
module bcd_digit_scanner
  import bcd_digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_digits,
  input  logic                        blank_leading,
  output logic [BCD_W-1:0]            bcd,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [IDX_W-1:0] idx_next;
  logic             slot_start, show_phase, frame_wrap;

  scan_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx_next  (idx_next),
    .slot_start(slot_start),
    .show_phase(show_phase),
    .frame_wrap(frame_wrap)
  );

  bcd_t [NUM_DIGITS-1:0] active_q, active_d;
  bcd_t [NUM_DIGITS-1:0] pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;
  bcd_t                  bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic                  load_accept, commit, suppress;

  always_comb begin
    load_accept    = load_valid && !pending_full_q;
    commit         = frame_wrap && pending_full_q;
    active_d       = commit ? pending_q : active_q;
    pending_d      = load_accept ? load_digits : pending_q;
    pending_full_d = load_accept || (pending_full_q && !commit);
    frame_tick_d   = frame_wrap;
  end

  // lead_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (active_d[i] == BCD_BLANK);
      lead_zero[i] = zero_run;
    end
  end

  // active only changes on a frame wrap, which is also a slot start, so the
  // digit code needs refreshing only when a new slot begins.
  always_comb begin
    bcd_d      = slot_start ? active_d[idx_next] : bcd_q;
    suppress   = !bcd_valid(bcd_d) ||
                 (blank_leading && (idx_next != '0) && lead_zero[idx_next]);
    digit_en_d = (show_phase && !suppress) ? (NUM_DIGITS'(1) << idx_next) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      bcd_q          <= BCD_BLANK;
      digit_en_q     <= '0;
      frame_tick_q   <= 1'b0;
    end else begin
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      bcd_q          <= bcd_d;
      digit_en_q     <= digit_en_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign load_ready = !pending_full_q;
  assign bcd        = bcd_q;
  assign digit_en   = digit_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Bench for bcd_digit_scanner: directed vector table, reset corner sequence,
// then random loads checked against a time-indexed reference model.
module tb_bcd_digit_scanner;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int NP = N * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_digits = '0;
  logic        blank_leading = 1'b0;
  logic        load_ready;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;
  logic        frame_tick;

  always #5 clk = ~clk;

  bcd_digit_scanner #(
    .NUM_DIGITS  (N),
    .PRESCALE    (P),
    .BLANK_CYCLES(B)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_digits  (load_digits),
    .blank_leading(blank_leading),
    .bcd          (bcd),
    .digit_en     (digit_en),
    .frame_tick   (frame_tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: t = cycles since reset release; everything else follows
  // from t, the committed value and the pending value.
  int          t = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_pending = '0;
  bit          m_full = 1'b0;
  bit          m_bl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    m_active  = '0;
    m_pending = '0;
    m_full    = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // return at the following falling edge.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (rst_n) begin
      acc = load_valid && !m_full;
      if ((t % NP) == NP - 1 && m_full) begin
        m_active = m_pending;
        m_full   = 1'b0;
      end
      if (acc) begin
        m_pending = load_digits;
        m_full    = 1'b1;
      end
      m_bl = blank_leading;
      t++;
    end
    @(negedge clk);
  endtask

  task automatic check_model();
    int   idx, cnt, d;
    bit   lz;
    logic [3:0] en;
    idx = (t / P) % N;
    cnt = t % P;
    d   = int'((m_active >> (4 * idx)) & 16'hF);
    lz  = ((m_active >> (4 * idx)) == 16'h0);
    en  = 4'b0000;
    if (cnt >= B && d <= 9 && !(m_bl && idx > 0 && lz)) en = 4'(1 << idx);
    chk("rnd_bcd", 32'(bcd), 32'(d));
    chk("rnd_en", 32'(digit_en), 32'(en));
    chk("rnd_tick", 32'(frame_tick), 32'((t > 0 && (t % NP) == 0) ? 1 : 0));
    chk("rnd_ready", 32'(load_ready), 32'(m_full ? 0 : 1));
    $display("rnd t=%0d idx=%0d cnt=%0d bcd=%0h en=%b tick=%0b ready=%0b", t, idx, cnt, bcd, digit_en, frame_tick, load_ready);
  endtask

  typedef struct {
    int          cyc;
    bit          lv;
    logic [15:0] ld;
    bit          bl;
    logic [3:0]  bcd;
    logic [3:0]  en;
    bit          ft;
    bit          rdy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          cnt;
    logic [15:0] v;
    int          cut;

    // {cycle, load_valid, load_digits, blank_leading, bcd, digit_en, frame_tick, load_ready}
    tbl.push_back('{  0, 0, 16'h0000, 0, 4'h0, 4'b0000, 0, 1});
    tbl.push_back('{  1, 1, 16'h1234, 0, 4'h0, 4'b0000, 0, 1});
    tbl.push_back('{  2, 0, 16'h0000, 0, 4'h0, 4'b0001, 0, 0});
    tbl.push_back('{ 31, 0, 16'h0000, 0, 4'h0, 4'b1000, 0, 0});
    tbl.push_back('{ 32, 0, 16'h0000, 0, 4'h4, 4'b0000, 1, 1});
    tbl.push_back('{ 33, 0, 16'h0000, 0, 4'h4, 4'b0000, 0, 1});
    tbl.push_back('{ 34, 0, 16'h0000, 0, 4'h4, 4'b0001, 0, 1});
    tbl.push_back('{ 39, 0, 16'h0000, 0, 4'h4, 4'b0001, 0, 1});
    tbl.push_back('{ 40, 0, 16'h0000, 0, 4'h3, 4'b0000, 0, 1});
    tbl.push_back('{ 41, 0, 16'h0000, 0, 4'h3, 4'b0000, 0, 1});
    tbl.push_back('{ 42, 0, 16'h0000, 0, 4'h3, 4'b0010, 0, 1});
    tbl.push_back('{ 47, 0, 16'h0000, 0, 4'h3, 4'b0010, 0, 1});
    tbl.push_back('{ 48, 0, 16'h0000, 0, 4'h2, 4'b0000, 0, 1});
    tbl.push_back('{ 58, 0, 16'h0000, 0, 4'h1, 4'b1000, 0, 1});
    // leading-zero suppression
    tbl.push_back('{ 60, 1, 16'h0050, 1, 4'h1, 4'b1000, 0, 1});
    tbl.push_back('{ 61, 0, 16'h0000, 1, 4'h1, 4'b1000, 0, 0});
    tbl.push_back('{ 64, 0, 16'h0000, 1, 4'h0, 4'b0000, 1, 1});
    tbl.push_back('{ 66, 0, 16'h0000, 1, 4'h0, 4'b0001, 0, 1});
    tbl.push_back('{ 74, 0, 16'h0000, 1, 4'h5, 4'b0010, 0, 1});
    tbl.push_back('{ 82, 0, 16'h0000, 1, 4'h0, 4'b0000, 0, 1});
    tbl.push_back('{ 90, 0, 16'h0000, 1, 4'h0, 4'b0000, 0, 1});
    // back-pressure and invalid digit
    tbl.push_back('{ 92, 1, 16'h12A4, 0, 4'h0, 4'b0000, 0, 1});
    tbl.push_back('{ 93, 0, 16'h0000, 0, 4'h0, 4'b1000, 0, 0});
    tbl.push_back('{ 94, 1, 16'h9999, 0, 4'h0, 4'b1000, 0, 0});
    tbl.push_back('{ 96, 1, 16'h9999, 0, 4'h4, 4'b0000, 1, 1});
    tbl.push_back('{ 97, 0, 16'h0000, 0, 4'h4, 4'b0000, 0, 0});
    tbl.push_back('{ 98, 0, 16'h0000, 0, 4'h4, 4'b0001, 0, 0});
    tbl.push_back('{106, 0, 16'h0000, 0, 4'hA, 4'b0000, 0, 0});
    tbl.push_back('{111, 0, 16'h0000, 0, 4'hA, 4'b0000, 0, 0});
    tbl.push_back('{114, 0, 16'h0000, 0, 4'h2, 4'b0100, 0, 0});
    tbl.push_back('{122, 0, 16'h0000, 0, 4'h1, 4'b1000, 0, 0});
    tbl.push_back('{128, 0, 16'h0000, 0, 4'h9, 4'b0000, 1, 1});
    tbl.push_back('{130, 0, 16'h0000, 0, 4'h9, 4'b0001, 0, 1});
    // load accepted on the commit edge waits a full frame
    tbl.push_back('{159, 1, 16'h0007, 0, 4'h9, 4'b1000, 0, 1});
    tbl.push_back('{160, 0, 16'h0000, 0, 4'h9, 4'b0000, 1, 0});
    tbl.push_back('{162, 0, 16'h0000, 0, 4'h9, 4'b0001, 0, 0});
    tbl.push_back('{191, 0, 16'h0000, 0, 4'h9, 4'b1000, 0, 0});
    tbl.push_back('{192, 0, 16'h0000, 0, 4'h7, 4'b0000, 1, 1});
    tbl.push_back('{194, 0, 16'h0000, 0, 4'h7, 4'b0001, 0, 1});
    tbl.push_back('{202, 0, 16'h0000, 0, 4'h0, 4'b0010, 0, 1});
    tbl.push_back('{210, 1, 16'h4321, 0, 4'h0, 4'b0100, 0, 1});
    tbl.push_back('{211, 0, 16'h0000, 0, 4'h0, 4'b0100, 0, 0});

    repeat (2) @(negedge clk);
    #1;
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_en", 32'(digit_en), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[r]) begin
      while (t < tbl[r].cyc) tick();
      load_valid    = tbl[r].lv;
      load_digits   = tbl[r].ld;
      blank_leading = tbl[r].bl;
      #1;
      chk("vec_bcd", 32'(bcd), 32'(tbl[r].bcd));
      chk("vec_en", 32'(digit_en), 32'(tbl[r].en));
      chk("vec_tick", 32'(frame_tick), 32'(tbl[r].ft));
      chk("vec_ready", 32'(load_ready), 32'(tbl[r].rdy));
      $display("vec t=%0d lv=%0b ld=%h bl=%0b bcd=%0h en=%b tick=%0b ready=%0b", t, tbl[r].lv, tbl[r].ld, tbl[r].bl, bcd, digit_en, frame_tick, load_ready);
      tick();
      load_valid = 1'b0;
    end

    // Reset mid-SHOW of idx 2 with a value pending: must clear instantly and discard it.
    while (t < 212) tick();
    chk("pre_rst_en", 32'(digit_en), 32'b0100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(digit_en), 32'h0);
    chk("mid_rst_bcd", 32'(bcd), 32'h0);
    chk("mid_rst_ready", 32'(load_ready), 32'h1);
    chk("mid_rst_tick", 32'(frame_tick), 32'h0);
    $display("reset mid-frame: bcd=%0h en=%b tick=%0b ready=%0b", bcd, digit_en, frame_tick, load_ready);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cnt = 0;
    while (!frame_tick && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("first_tick_cycle", 32'(cnt), 32'd32);
    chk("discarded_bcd", 32'(bcd), 32'h0);
    chk("post_rst_ready", 32'(load_ready), 32'h1);
    $display("first frame_tick after reset at cycle %0d, bcd=%0h", cnt, bcd);

    // Random loads and blank_leading changes against the model.
    for (int i = 0; i < 2000; i++) begin
      check_model();
      v = '0;
      for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 2) == 0) begin
        cut = $urandom_range(1, 3);
        for (int k = 0; k < 4; k++) if (k >= cut) v[4*k +: 4] = 4'h0;
      end
      load_valid  = ($urandom_range(0, 5) == 0);
      load_digits = v;
      if ($urandom_range(0, 39) == 0) blank_leading = ~blank_leading;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
